// File: rtl/sap_controller_if.sv
// rtl/sap_controller_if.sv - control bundle between the SAP-1 sequencer and its datapath
// The sequencer drives every load/enable line; the datapath returns the IR opcode nibble.
interface sap_controller_if;
  logic [3:0] ir_opcode;
  logic       pc_en;
  logic       pc_inc;
  logic       mar_load;
  logic       mem_en;
  logic       ir_load;
  logic       ir_en;
  logic       a_load;
  logic       a_en;
  logic       b_load;
  logic       adder_en;
  logic       sub;
  logic       out_load;
  logic [5:0] t_state;
  logic       halted;

  modport master (
    input  ir_opcode,
    output pc_en, pc_inc, mar_load, mem_en, ir_load, ir_en,
    output a_load, a_en, b_load, adder_en, sub, out_load,
    output t_state, halted
  );

  modport slave (
    output ir_opcode,
    input  pc_en, pc_inc, mar_load, mem_en, ir_load, ir_en,
    input  a_load, a_en, b_load, adder_en, sub, out_load,
    input  t_state, halted
  );
endinterface

// File: rtl/sap_controller.sv
// rtl/sap_controller.sv - SAP-1 six-state ring sequencer with opcode decode
// One fixed six-cycle instruction: T1..T3 fetch, T4..T6 execute; HLT freezes until reset.
module sap_controller #(
  parameter logic [3:0] OP_LDA = 4'h0,
  parameter logic [3:0] OP_ADD = 4'h1,
  parameter logic [3:0] OP_SUB = 4'h2,
  parameter logic [3:0] OP_OUT = 4'hE,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic            clk,
  input  logic            rst,
  sap_controller_if.master bus
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } ring_e;

  // Control word bit positions, MSB first in port order.
  localparam int B_PC_EN    = 11;
  localparam int B_PC_INC   = 10;
  localparam int B_MAR_LOAD = 9;
  localparam int B_MEM_EN   = 8;
  localparam int B_IR_LOAD  = 7;
  localparam int B_IR_EN    = 6;
  localparam int B_A_LOAD   = 5;
  localparam int B_A_EN     = 4;
  localparam int B_B_LOAD   = 3;
  localparam int B_ADDER_EN = 2;
  localparam int B_SUB      = 1;
  localparam int B_OUT_LOAD = 0;

  ring_e       ring_q, ring_d;
  logic        halt_q, halt_d;
  logic [11:0] ctrl_raw;
  logic [11:0] ctrl;

  always_comb begin
    ring_d = ring_q;
    halt_d = halt_q;
    case (ring_q)
      T1: if (!halt_q) ring_d = T2;
      T2: if (!halt_q) ring_d = T3;
      T3: if (!halt_q) ring_d = T4;
      T4: begin
        if (!halt_q) begin
          ring_d = T5;
          if (bus.ir_opcode == OP_HLT) halt_d = 1'b1;
        end
      end
      T5: if (!halt_q) ring_d = T6;
      T6: if (!halt_q) ring_d = T1;
      // A corrupted ring is pulled back to a clean fetch.
      default: ring_d = T1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ring_q <= T1;
      halt_q <= 1'b0;
    end else begin
      ring_q <= ring_d;
      halt_q <= halt_d;
    end
  end

  always_comb begin
    ctrl_raw = '0;
    case (ring_q)
      T1: begin
        ctrl_raw[B_PC_EN]    = 1'b1;
        ctrl_raw[B_MAR_LOAD] = 1'b1;
      end
      T2: ctrl_raw[B_PC_INC] = 1'b1;
      T3: begin
        ctrl_raw[B_MEM_EN]  = 1'b1;
        ctrl_raw[B_IR_LOAD] = 1'b1;
      end
      T4: begin
        if (bus.ir_opcode == OP_LDA || bus.ir_opcode == OP_ADD ||
            bus.ir_opcode == OP_SUB) begin
          ctrl_raw[B_IR_EN]    = 1'b1;
          ctrl_raw[B_MAR_LOAD] = 1'b1;
        end else if (bus.ir_opcode == OP_OUT) begin
          ctrl_raw[B_A_EN]     = 1'b1;
          ctrl_raw[B_OUT_LOAD] = 1'b1;
        end
      end
      T5: begin
        if (bus.ir_opcode == OP_LDA) begin
          ctrl_raw[B_MEM_EN] = 1'b1;
          ctrl_raw[B_A_LOAD] = 1'b1;
        end else if (bus.ir_opcode == OP_ADD || bus.ir_opcode == OP_SUB) begin
          ctrl_raw[B_MEM_EN] = 1'b1;
          ctrl_raw[B_B_LOAD] = 1'b1;
        end
      end
      T6: begin
        if (bus.ir_opcode == OP_ADD || bus.ir_opcode == OP_SUB) begin
          ctrl_raw[B_ADDER_EN] = 1'b1;
          ctrl_raw[B_A_LOAD]   = 1'b1;
          ctrl_raw[B_SUB]      = (bus.ir_opcode == OP_SUB);
        end
      end
      default: ctrl_raw = '0;
    endcase
  end

  // Reset and HALT both silence the datapath in the same cycle they apply.
  always_comb begin
    ctrl = ctrl_raw;
    if (rst || halt_q) ctrl = '0;
  end

  assign bus.pc_en    = ctrl[B_PC_EN];
  assign bus.pc_inc   = ctrl[B_PC_INC];
  assign bus.mar_load = ctrl[B_MAR_LOAD];
  assign bus.mem_en   = ctrl[B_MEM_EN];
  assign bus.ir_load  = ctrl[B_IR_LOAD];
  assign bus.ir_en    = ctrl[B_IR_EN];
  assign bus.a_load   = ctrl[B_A_LOAD];
  assign bus.a_en     = ctrl[B_A_EN];
  assign bus.b_load   = ctrl[B_B_LOAD];
  assign bus.adder_en = ctrl[B_ADDER_EN];
  assign bus.sub      = ctrl[B_SUB];
  assign bus.out_load = ctrl[B_OUT_LOAD];

  assign bus.t_state  = rst ? 6'b000001 : (halt_q ? 6'b000000 : ring_q);
  assign bus.halted   = halt_q & ~rst;

endmodule
